// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: column geometry, FSM encodings, helpers.
package aes_pkg;

   localparam int AES_NB    = 4;
   localparam int AES_COL_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_state_e;

   // Column c of a 128-bit state; column 0 occupies the top 32 bits.
   function automatic logic [AES_COL_W-1:0] aes_get_col(input logic [127:0] s,
                                                        input logic [1:0]   c);
      return s[127 - AES_COL_W*int'(c) -: AES_COL_W];
   endfunction

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] gf_xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/byte_mixcolum.sv
// One output byte of MixColumns (outx) and InvMixColumns (outy) for inputs (a,b,c,d).
module byte_mixcolum
   import aes_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   output logic [7:0] outx,
   output logic [7:0] outy
);

   logic [7:0] a2, a4, a8;
   logic [7:0] b2, b4, b8;
   logic [7:0] c2, c4, c8;
   logic [7:0] d2, d4, d8;

   // Powers of x per input byte, shared by both directions.
   always_comb begin
      a2 = gf_xtime(a);  a4 = gf_xtime(a2);  a8 = gf_xtime(a4);
      b2 = gf_xtime(b);  b4 = gf_xtime(b2);  b8 = gf_xtime(b4);
      c2 = gf_xtime(c);  c4 = gf_xtime(c2);  c8 = gf_xtime(c4);
      d2 = gf_xtime(d);  d4 = gf_xtime(d2);  d8 = gf_xtime(d4);
   end

   // outx = 2a ^ 3b ^ c ^ d ; outy = 14a ^ 11b ^ 13c ^ 9d
   always_comb begin
      outx = a2 ^ b2 ^ b ^ c ^ d;
      outy = (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
   end

endmodule

// File: rtl/word_mixcolum.sv
// Full-column (Inv)MixColumns: four byte_mixcolum lanes fed rotated copies of the column.
module word_mixcolum
   import aes_pkg::*;
(
   input  logic [AES_COL_W-1:0] in,
   input  logic                 decrypt,
   output logic [AES_COL_W-1:0] out
);

   logic [AES_NB-1:0][7:0] outx;
   logic [AES_NB-1:0][7:0] outy;

   // Row r sees the column rotated up by r bytes; row 0 is the MSB byte.
   for (genvar r = 0; r < AES_NB; r++) begin : g_row
      byte_mixcolum u_byte (
         .a    (in[31 - 8*r           -: 8]),
         .b    (in[31 - 8*((r+1) % 4) -: 8]),
         .c    (in[31 - 8*((r+2) % 4) -: 8]),
         .d    (in[31 - 8*((r+3) % 4) -: 8]),
         .outx (outx[r]),
         .outy (outy[r])
      );
      assign out[31 - 8*r -: 8] = decrypt ? outy[r] : outx[r];
   end

endmodule

// File: rtl/mixcolum_iter.sv
// Iterative MixColumns/InvMixColumns stage: transforms COLS_PER_CYCLE columns per clock
// in place in a 128-bit state register, handshaking on both sides.
// COLS_PER_CYCLE must be 1, 2 or 4 so that the column counter wraps exactly at the end.
module mixcolum_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         decrypt,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out
);

   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(AES_NB - COLS_PER_CYCLE);

   aes_state_e   st_q, st_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [127:0] data_q, data_d;
   logic         mode_q, mode_d;

   logic [COLS_PER_CYCLE-1:0][1:0]           col_idx;
   logic [COLS_PER_CYCLE-1:0][AES_COL_W-1:0] word_in;
   logic [COLS_PER_CYCLE-1:0][AES_COL_W-1:0] word_out;

   // One column transformer per lane; lane g handles column cnt_q+g.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_idx[g] = cnt_q + 2'(g);
      assign word_in[g] = aes_get_col(data_q, col_idx[g]);
      word_mixcolum u_word (
         .in      (word_in[g]),
         .decrypt (mode_q),
         .out     (word_out[g])
      );
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) st_q <= ST_IDLE;
      else        st_q <= st_d;
   end

   // FSM next state.
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (in_valid)          st_d = ST_BUSY;
         ST_BUSY: if (cnt_q == LAST_CNT) st_d = ST_DONE;
         ST_DONE: if (out_ready)         st_d = ST_IDLE;
         default:                        st_d = ST_IDLE;
      endcase
   end

   // FSM outputs; data_out comes only from the state register.
   always_comb begin
      in_ready  = (st_q == ST_IDLE);
      out_valid = (st_q == ST_DONE);
      data_out  = data_q;
   end

   // Datapath next values: load on accept, in-place column write-back while busy.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      case (st_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d = data_in;
               mode_d = decrypt;
               cnt_d  = 2'd0;
            end
         end
         ST_BUSY: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++)
               data_d[127 - AES_COL_W*int'(col_idx[g]) -: AES_COL_W] = word_out[g];
            cnt_d = cnt_q + CNT_STEP;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q <= '0;
         cnt_q  <= 2'd0;
         mode_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
      end
   end

endmodule

// File: tb/tb_mixcolum_iter.sv
// Directed bench for mixcolum_iter with a GF(2^8) reference model and output scoreboards.
module tb_mixcolum_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // COLS_PER_CYCLE = 1 instance
   logic         iv1, ir1, dec1, ov1, or1;
   logic [127:0] din1, dout1;
   // COLS_PER_CYCLE = 4 instance
   logic         iv4, ir4, dec4, ov4, or4;
   logic [127:0] din4, dout4;

   mixcolum_iter #(.COLS_PER_CYCLE(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .decrypt(dec1),
      .data_in(din1), .out_valid(ov1), .out_ready(or1), .data_out(dout1));

   mixcolum_iter #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .decrypt(dec4),
      .data_in(din4), .out_valid(ov4), .out_ready(or4), .data_out(dout4));

   int tests = 0;
   int fails = 0;
   logic [127:0] q1[$];
   logic [127:0] q4[$];

   // Reference: generic GF(2^8) shift-and-add multiply, poly 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic dec);
      logic [127:0] r;
      logic [7:0] k0, k1, k2, k3;
      logic [7:0] v [4];
      k0 = dec ? 8'h0e : 8'h02; k1 = dec ? 8'h0b : 8'h03;
      k2 = dec ? 8'h0d : 8'h01; k3 = dec ? 8'h09 : 8'h01;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) v[i] = s[127 - 32*c - 8*i -: 8];
         for (int row = 0; row < 4; row++)
            r[127 - 32*c - 8*row -: 8] = gmul(k0, v[row]) ^ gmul(k1, v[(row+1)%4]) ^
                                         gmul(k2, v[(row+2)%4]) ^ gmul(k3, v[(row+3)%4]);
      end
      return r;
   endfunction

   function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endfunction

   // Scoreboards: pop on each completed output handshake (sampled mid-cycle).
   always @(negedge clk) begin
      if (reset && ov1 && or1) begin
         if (q1.size() == 0) chk("sb1_unexpected", dout1, 128'hx);
         else chk("sb1", dout1, q1.pop_front());
      end
      if (reset && ov4 && or4) begin
         if (q4.size() == 0) chk("sb4_unexpected", dout4, 128'hx);
         else chk("sb4", dout4, q4.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Accept one state on dut1 and return cycles until out_valid (0 on timeout).
   task automatic send1(input logic [127:0] d, input logic dec, input logic toggle_mode,
                        output int lat);
      chk("pre_accept_in_ready", 128'(ir1), 128'(1));
      iv1 = 1'b1; din1 = d; dec1 = dec;
      q1.push_back(model(d, dec));
      tick();
      iv1 = 1'b0; din1 = '0;
      if (toggle_mode) dec1 = ~dec;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         if (ov1) begin lat = i - 1; break; end
         tick();
      end
      dec1 = 1'b0;
   endtask

   localparam logic [127:0] V_ENC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V_ENC_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V_BP_IN   = {4{32'hd4d4d4d5}};
   localparam logic [127:0] V_BP_OUT  = {4{32'hd5d5d7d6}};
   localparam logic [127:0] V_RS_IN   = {4{32'h2d26314c}};
   localparam logic [127:0] V_RS_OUT  = {4{32'h4d7ebdf8}};

   initial begin
      int lat;
      int cyc, n_acc, n_out;
      int acc_cyc [2];
      logic acc;
      logic [127:0] exp4 [2];

      reset = 1'b0;
      iv1 = 0; dec1 = 0; din1 = '0; or1 = 1;
      iv4 = 0; dec4 = 0; din4 = '0; or4 = 1;
      tick(); tick();
      chk("rst_in_ready",  128'(ir1),  128'(1));
      chk("rst_out_valid", 128'(ov1),  128'(0));
      chk("rst_data_out",  dout1,      128'(0));
      reset = 1'b1;
      tick();

      // Encrypt with latency check
      send1(V_ENC_IN, 1'b0, 1'b0, lat);
      chk("enc_latency", 128'(lat), 128'(4));
      chk("enc_data", dout1, V_ENC_OUT);
      tick();
      chk("enc_drop_valid", 128'(ov1), 128'(0));
      chk("enc_idle_ready", 128'(ir1), 128'(1));

      // Decrypt round trip
      send1(V_ENC_OUT, 1'b1, 1'b0, lat);
      chk("dec_latency", 128'(lat), 128'(4));
      chk("dec_data", dout1, V_ENC_IN);
      tick();

      // Backpressure: hold result for 10 cycles, poke in_valid meanwhile
      or1 = 1'b0;
      send1(V_BP_IN, 1'b0, 1'b0, lat);
      chk("bp_latency", 128'(lat), 128'(4));
      for (int i = 0; i < 10; i++) begin
         iv1 = i[0]; din1 = V_RS_IN;
         tick();
         chk("bp_valid_hold", 128'(ov1), 128'(1));
         chk("bp_in_ready",   128'(ir1), 128'(0));
         chk("bp_data_hold",  dout1,     V_BP_OUT);
      end
      iv1 = 1'b0; din1 = '0;
      or1 = 1'b1;
      tick();
      chk("bp_release_valid", 128'(ov1), 128'(0));
      chk("bp_release_ready", 128'(ir1), 128'(1));

      // Reset during the second BUSY cycle; aborted op expects nothing
      iv1 = 1'b1; din1 = V_ENC_IN; dec1 = 1'b0;
      tick();
      iv1 = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_out_valid", 128'(ov1), 128'(0));
      chk("mid_rst_in_ready",  128'(ir1), 128'(1));
      chk("mid_rst_data_out",  dout1,     128'(0));
      reset = 1'b1;
      send1(V_RS_IN, 1'b0, 1'b0, lat);
      chk("post_rst_latency", 128'(lat), 128'(4));
      chk("post_rst_data", dout1, V_RS_OUT);
      tick();

      // Mode latch: external decrypt flips during BUSY
      send1(V_ENC_IN, 1'b0, 1'b1, lat);
      chk("mode_latch_data", dout1, V_ENC_OUT);
      tick();

      // COLS_PER_CYCLE=4 back-to-back with in_valid held high
      exp4[0] = V_ENC_OUT;
      exp4[1] = V_ENC_IN;
      iv4 = 1'b1; din4 = V_ENC_IN; dec4 = 1'b0;
      cyc = 0; n_acc = 0; n_out = 0;
      for (int i = 0; i < 30 && n_out < 2; i++) begin
         acc = iv4 && ir4;
         if (acc) q4.push_back(model(din4, dec4));
         tick();
         cyc++;
         if (acc) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1) begin din4 = V_ENC_OUT; dec4 = 1'b1; end
            else begin iv4 = 1'b0; din4 = '0; dec4 = 1'b0; end
         end
         if (ov4 && n_out < n_acc) begin
            chk("b2b_latency", 128'(cyc - acc_cyc[n_out]), 128'(1));
            chk("b2b_data", dout4, exp4[n_out]);
            n_out++;
         end
      end
      chk("b2b_outputs", 128'(n_out), 128'(2));
      if (n_acc == 2) chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(3));
      else chk("b2b_accepts", 128'(n_acc), 128'(2));
      iv4 = 1'b0;

      tick(); tick(); tick();
      chk("sb1_drained", 128'(q1.size()), 128'(0));
      chk("sb4_drained", 128'(q4.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mixcolum_iter.md
Name: mixcolum_iter

Overview:
- Sequential MixColumns / InvMixColumns stage for the AES-128 round datapath.
- Accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE 32-bit columns per clock.
- Each column passes through one word_mixcolum instance, built from four byte_mixcolum instances.
- Presents the 128-bit result to the next stage (AddRoundKey) over a valid/ready handshake.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; compute latency = 4/COLS_PER_CYCLE cycles.

Ports:
- clk  input  1  clock; all flops update on its rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- in_valid  input  1  upstream presents a state on data_in.
- in_ready  output  1  block can accept a state; high only in IDLE.
- decrypt  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with data_in on acceptance.
- data_in  input  128  input state; byte0 = [127:120]; column c = [127-32c -: 32]; rows 0..3 MSB first within a column.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  downstream accepts the result.
- data_out  output  128  result state, same byte ordering as data_in.

Behaviour:
- Reset (reset==0 at a rising edge), regardless of state, including mid-operation:
  - state = IDLE, column counter = 0, state register = 0, mode flop = 0.
  - out_valid = 0, in_ready = 1 after the reset edge, data_out = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load data_in into the 128-bit state register, latch decrypt, counter = 0, go to BUSY.
- BUSY:
  - Each cycle, columns counter .. counter+COLS_PER_CYCLE-1 are read from the state register, transformed, and written back in place; counter += COLS_PER_CYCLE.
  - When the last column is written, go to DONE.
  - in_valid is ignored.
  - Changes on the external decrypt input have no effect; the latched mode bit is used.
- Column transform, column bytes (a,b,c,d):
  - new row0 = f(a,b,c,d); row1 = f(b,c,d,a); row2 = f(c,d,a,b); row3 = f(d,a,b,c).
  - f is the byte_mixcolum function: outx for encrypt, outy for decrypt.
  - All arithmetic is GF(2^8) with polynomial 0x11B, 8-bit, no carries.
- DONE:
  - out_valid = 1; data_out = state register, stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- data_out is driven from the register only, never combinationally from data_in.
- Latency with COLS_PER_CYCLE=1: accept at edge N, out_valid=1 after edge N+4, earliest new accept at edge N+6 (one IDLE cycle).
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles; no overlap between operations.
- Simultaneous events:
  - in_valid asserted while in DONE: not accepted (in_ready=0); upstream must hold.
  - out_ready high before out_valid: no effect.
  - Reset asserted in the same cycle as an acceptance: reset wins, nothing is loaded.
- Counter: 2 bits, wraps only through the FSM. Counter is a don't-care outside BUSY but is forced to 0 on entry to BUSY.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_NB=4 and AES_COL_W=32;
  - state encodings ST_IDLE, ST_BUSY, ST_DONE;
  - a column-extract helper indexed by column number.
- Sub-module word_mixcolum(in[31:0], decrypt, out[31:0]): four byte_mixcolum instances with rotated inputs plus an outx/outy mux per byte.
- mixcolum_iter instantiates COLS_PER_CYCLE copies of word_mixcolum via generate.

Test Plan:
- Encrypt, COLS=1: data_in = db135345_f20a225c_01010101_c6c6c6c6, decrypt=0 -> data_out = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid exactly 4 cycles after acceptance.
- Decrypt round-trip: data_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, decrypt=1 -> data_out = db135345_f20a225c_01010101_c6c6c6c6.
- Backpressure: column d4d4d4d5 repeated ×4, out_ready held 0 for 10 cycles -> data_out stays d5d5d7d6 ×4 and out_valid stays 1; in_ready=0 throughout; in_valid pulses during that time are not accepted.
- Reset mid-BUSY: assert reset=0 at the 2nd BUSY cycle -> next cycle out_valid=0, in_ready=1, data_out=0; a new input 2d26314c ×4 then yields 4d7ebdf8 ×4.
- Mode latch: accept with decrypt=0, toggle decrypt to 1 during BUSY -> result equals pure MixColumns.
- Back-to-back with COLS_PER_CYCLE=4: two states queued with in_valid held high and out_ready=1 -> each result 1 cycle after its acceptance; accepts spaced 3 cycles apart; both results correct.
